// File: rtl/alu_op_issuer_if.sv
// Request, ALU and response signals of the ALU op issuer, bundled as one interface.
// master = issuer view, slave = sequencer/ALU/consumer view.
interface alu_op_issuer_if #(parameter int N = 8);
  logic         req_valid;
  logic         req_ready;
  logic [2:0]   req_selop;
  logic [N-1:0] req_operand;
  logic         req_wr_acc;
  logic [N-1:0] alu_dataa;
  logic [N-1:0] alu_datab;
  logic [2:0]   alu_selop;
  logic [N-1:0] alu_result;
  logic         alu_cout;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [N-1:0] rsp_result;
  logic [3:0]   rsp_flags;
  logic [N-1:0] acc;

  modport master (
    input  req_valid, req_selop, req_operand, req_wr_acc,
    input  alu_result, alu_cout, rsp_ready,
    output req_ready, alu_dataa, alu_datab, alu_selop,
    output rsp_valid, rsp_result, rsp_flags, acc
  );

  modport slave (
    output req_valid, req_selop, req_operand, req_wr_acc,
    output alu_result, alu_cout, rsp_ready,
    input  req_ready, alu_dataa, alu_datab, alu_selop,
    input  rsp_valid, rsp_result, rsp_flags, acc
  );
endinterface

// File: rtl/alu_op_issuer.sv
// ALU op issuer: drives operands/opcode to a combinational ALU, captures result and flags
// {V,C,N,Z}, and maintains the accumulator. Define ALU_OVF_EN to compute the V flag.
module alu_op_issuer #(
  parameter int N = 8
) (
  input  logic          clk,
  input  logic          rst,
  alu_op_issuer_if.master bus
);

  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

  state_t       state, state_next;
  logic [N-1:0] acc_q;
  logic [N-1:0] datab_q;
  logic [2:0]   selop_q;
  logic         wr_acc_q;
  logic [N-1:0] result_q;
  logic [3:0]   flags_q;
  logic [3:0]   flags_d;
  logic         accept;
  logic         carry;
  logic         ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          accept     = 1'b1;
          state_next = DRIVE;
        end
      end
      DRIVE:   state_next = RESP;
      RESP:    if (bus.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The ALU carry mux keys on selop[1:0]; only the arithmetic opcodes may report C.
  always_comb begin
    carry = bus.alu_cout & selop_q[2] & (selop_q[1:0] != 2'b00);
    ovf   = 1'b0;
`ifdef ALU_OVF_EN
    case (selop_q)
      3'b101:  ovf = (acc_q[N-1] == datab_q[N-1]) && (bus.alu_result[N-1] != acc_q[N-1]);
      3'b110:  ovf = (datab_q == {1'b0, {(N-1){1'b1}}});
      3'b111:  ovf = (datab_q == {1'b1, {(N-1){1'b0}}});
      default: ovf = 1'b0;
    endcase
`endif
    flags_d = {ovf, carry, bus.alu_result[N-1], (bus.alu_result == '0)};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      datab_q  <= '0;
      selop_q  <= '0;
      wr_acc_q <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      if (accept) begin
        datab_q  <= bus.req_operand;
        selop_q  <= bus.req_selop;
        wr_acc_q <= bus.req_wr_acc;
      end
      if (state == DRIVE) begin
        result_q <= bus.alu_result;
        flags_q  <= flags_d;
        if (wr_acc_q) acc_q <= bus.alu_result;
      end
    end
  end

  // rsp_valid is exactly "in RESP", so it is decoded from the state register rather than stored twice.
  assign bus.req_ready  = (state == IDLE) && !rst;
  assign bus.rsp_valid  = (state == RESP);
  assign bus.alu_dataa  = acc_q;
  assign bus.alu_datab  = datab_q;
  assign bus.alu_selop  = selop_q;
  assign bus.rsp_result = result_q;
  assign bus.rsp_flags  = flags_q;
  assign bus.acc        = acc_q;

endmodule

// File: doc/alu_op_issuer.md
Name: alu_op_issuer

Overview:
Initiator side of the ALU operand/opcode interface. Accepts one ALU request per valid/ready handshake and drives operands and opcode to the combinational processing unit. Samples its result and carry, updates an internal accumulator and a flag set, and returns a response via a second valid/ready handshake. Sits between the PDUA control sequencer and the ALU datapath.

Parameters:
N, 8, datapath width of operands, result and accumulator.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
req_valid  input  1  request present.
req_ready  output  1  issuer can accept a request.
req_selop  input  3  ALU opcode: 000 B, 001 ~B, 010 A&B, 011 A|B, 100 A^B, 101 A+B, 110 B+1, 111 -B.
req_operand  input  N  B operand.
req_wr_acc  input  1  1 = write result into the accumulator.
alu_dataa  output  N  A operand to the ALU; always equals the accumulator.
alu_datab  output  N  B operand to the ALU; registered.
alu_selop  output  3  opcode to the ALU; registered.
alu_result  input  N  ALU result, combinational from the alu_* outputs.
alu_cout  input  1  ALU carry-out.
rsp_valid  output  1  response present.
rsp_ready  input  1  consumer takes the response.
rsp_result  output  N  captured ALU result.
rsp_flags  output  4  {V,C,N,Z}.
acc  output  N  accumulator value.

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE.
  - acc, alu_datab, alu_selop, rsp_result, rsp_flags all 0.
  - rsp_valid=0.
  - req_ready=1 once reset is released.
- FSM states: IDLE, DRIVE, RESP.
- IDLE:
  - req_ready=1.
  - On a rising edge with req_valid&req_ready: alu_datab<=req_operand, alu_selop<=req_selop, wr_acc latched; go to DRIVE.
- DRIVE:
  - req_ready=0.
  - The ALU inputs are held stable for one full cycle.
  - On the next edge: rsp_result<=alu_result, flags computed; if the latched wr_acc=1 then acc<=alu_result; rsp_valid<=1; go to RESP.
- RESP:
  - rsp_valid=1; rsp_result and rsp_flags held stable.
  - On an edge with rsp_ready=1: rsp_valid<=0 and go to IDLE.
  - No request overlap: req_ready rises the cycle after the response is taken.
- Latency:
  - Request accepted at edge k.
  - rsp_valid high after edge k+1.
  - Minimum 3 cycles per request when rsp_ready is held at 1.
- Flags, sampled together with the result:
  - Z = (alu_result==0).
  - N = alu_result[N-1].
  - C = alu_cout only for selop in {101,110,111}; forced to 0 otherwise. The ALU carry mux keys on selop[1:0], so opcode 001 would otherwise leak the add carry.
  - V = 0 unless ALU_OVF_EN is defined.
- Accumulator:
  - Changes only at the DRIVE->RESP edge, and only when wr_acc=1.
  - alu_dataa tracks acc continuously; no separate register.
- Arithmetic: all results are modulo 2^N. The issuer does no arithmetic of its own beyond flag extraction.
- Input sampling: req_* is sampled only on the accepting edge. Changes to req_* while busy are ignored.
- rsp_ready held high while rsp_valid=0 has no effect.

Optional Feature:
ALU_OVF_EN:
- Defined: rsp_flags[3]=V, the two's-complement overflow.
  - selop 101: V = (acc[N-1]==B[N-1]) & (alu_result[N-1]!=acc[N-1]).
  - selop 110: V = (B == 0 followed by N-1 ones).
  - selop 111: V = (B == 1 followed by N-1 zeros).
  - All other opcodes: V=0.
- Not defined: rsp_flags[3] is tied to 0 and no overflow logic is present.

Test Plan:
1. Assert rst mid-cycle -> all outputs 0 immediately; req_ready=1 after release.
2. Request selop 000, operand 0x7F, wr_acc=1, then selop 101, operand 0x01, wr_acc=1 -> responses 0x7F with flags 0000, then 0x80 with N=1, C=0, and V=1 only with ALU_OVF_EN; acc=0x80.
3. Load acc=0xFF, then selop 101, operand 0x01 -> rsp_result 0x00, Z=1, C=1, V=0.
4. Load acc=0xFF, then selop 001, operand 0x00 (ALU cout=1) -> rsp_result 0xFF, N=1, C=0 (masked).
5. Hold rsp_ready=0 for 3 cycles in RESP while req_valid=1 -> rsp_valid and rsp_result stay stable, req_ready=0, the second request is accepted only after the response is taken.
6. Assert rst during DRIVE on a request with wr_acc=1 -> rsp_valid never rises, acc=0, FSM returns to IDLE.
